dec_83: RTL and testbench
=========================

# dec_83

Registered 3-to-8 line decoder with enable. It converts a 3-bit select formed from single-bit inputs x, y and z into a one-hot 8-bit output D. It sits at the select/address-decode stage, driving one-of-eight enables for downstream blocks. Output polarity is selectable at elaboration, and a registered copy of the decoded code plus a valid flag accompany the output.

## Interface
Parameters:
- ACTIVE_LOW, default 0: 0 = the selected D bit is 1 and the others are 0. 1 = the selected D bit is 0 and the others are 1.

Ports:
- clk, input, 1: rising-edge clock; the single clock domain.
- rst, input, 1: reset, asynchronous and active-high.
- en, input, 1: decode enable, sampled on the clk rising edge.
- x, input, 1: select MSB (weight 4).
- y, input, 1: select middle bit (weight 2).
- z, input, 1: select LSB (weight 1).
- D, output, 8: decoded one-hot output, registered; D[i] corresponds to select value i.
- valid, output, 1: D holds a decode of an enabled sample.
- code, output, 3: registered select value {x,y,z} that produced the current D.

## Operation
- Select index: idx = {x,y,z} = 4·x + 2·y + z, in the range 0..7.
- On a clk rising edge with en=1:
  - the active one-hot value is 8'b1 << idx;
  - D loads that value, or its bitwise inverse when ACTIVE_LOW=1;
  - code loads idx;
  - valid loads 1.
- On a clk rising edge with en=0:
  - D loads the all-inactive value: 8'h00, or 8'hFF when ACTIVE_LOW=1;
  - valid loads 0;
  - code holds its previous value.
- Exactly one D bit is asserted whenever valid=1. No D bit is asserted whenever valid=0.
- x, y and z are sampled together. There is no priority between them, and every one of the 8 combinations is legal.
- Select changes between clock edges have no effect until the next rising edge. The block contains no combinational path from inputs to outputs.
- The block has no other state: no FSM, counters or handshake.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on D, code and valid immediately after edge N.
- Throughput: one decode per cycle. The select may change every cycle.
- Reset, asynchronous:
  - while rst=1, D = inactive value (8'h00, or 8'hFF with ACTIVE_LOW=1), valid = 0, code = 3'b000;
  - outputs change immediately on rst assertion, independent of clk.
- Reset release: the first decode is captured on the first rising edge after rst deasserts, provided en=1.
- Reset asserted mid-stream: any in-flight decode is discarded and outputs go to reset values at once.
- en and the select changing on the same edge: the new values are used, since all inputs are sampled together.
- Glitch-free outputs: all outputs come directly from flops.

## Test plan
- Reset: assert rst with en=1 and xyz=101, and no clock edge. Required: D=8'h00, valid=0, code=000 immediately. Release rst, then one edge. Required: D=8'h20, code=101, valid=1.
- Exhaustive sweep, ACTIVE_LOW=0, en=1: apply xyz = 000, 001, …, 111 on consecutive cycles, one per edge. Required, one cycle later per input:
  - D = 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80 respectively;
  - code tracks idx;
  - valid=1 throughout.
- Active-low build, ACTIVE_LOW=1:
  - xyz=011 with en=1. Required: D=8'hF7 after one edge.
  - Reset. Required: D=8'hFF, valid=0.
- Enable gating: decode xyz=110 (D=8'h40), then drop en=0 and change xyz=001. Required after the next edge: D=8'h00, valid=0, code stays 110. Re-enable. Required: D=8'h02, code=001.
- Asynchronous reset mid-stream: while sweeping with en=1, pulse rst between clock edges. Required: D, valid and code reach reset values without waiting for a clock edge. Decoding resumes on the first edge after release.
- Input setup/latency: change xyz mid-cycle from 010 to 100. Required: D stays 8'h04 until the next edge, then becomes 8'h10. D never shows more than one bit set.

Source files
------------

// File: rtl/dec_83.sv
// Registered 3-to-8 decoder with enable and elaboration-time output polarity.
// Every output comes straight from a flop, so downstream enables never see decode glitches.
module dec_83 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       x,
    input  logic       y,
    input  logic       z,
    output logic [7:0] D,
    output logic       valid,
    output logic [2:0] code
);

    localparam logic [7:0] INACTIVE = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [2:0] idx;
    logic [7:0] onehot;
    logic [7:0] decoded;

    assign idx = {x, y, z};

    always_comb begin
        onehot      = 8'h00;
        onehot[idx] = 1'b1;
        decoded     = ACTIVE_LOW ? ~onehot : onehot;
    end

    // code keeps the last enabled select while disabled; only D and valid fall idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D     <= INACTIVE;
            valid <= 1'b0;
            code  <= 3'b000;
        end else if (en) begin
            D     <= decoded;
            valid <= 1'b1;
            code  <= idx;
        end else begin
            D     <= INACTIVE;
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dec_83.sv
// Directed bench for dec_83: active-high and active-low builds driven side by side.
module tb_dec_83;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       x = 1'b0, y = 1'b0, z = 1'b0;
    logic [7:0] d_h, d_l;
    logic       valid_h, valid_l;
    logic [2:0] code_h, code_l;

    int checks = 0;
    int errors = 0;

    dec_83 #(.ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .z(z),
        .D(d_h), .valid(valid_h), .code(code_h)
    );

    dec_83 #(.ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .z(z),
        .D(d_l), .valid(valid_l), .code(code_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [2:0] s);
        {x, y, z} = s;
    endtask

    initial begin
        // asynchronous reset with no clock edge (first posedge is at t=5)
        en = 1'b1;
        set_sel(3'b101);
        #2 rst = 1'b1;
        #1;
        check("rst_d_h", d_h, 8'h00);
        check("rst_valid_h", valid_h, 1'b0);
        check("rst_code_h", code_h, 3'b000);
        check("rst_d_l", d_l, 8'hFF);
        check("rst_valid_l", valid_l, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rel_d_h", d_h, 8'h20);
        check("rel_code_h", code_h, 3'b101);
        check("rel_valid_h", valid_h, 1'b1);

        // exhaustive sweep, one select per edge
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_sel(i[2:0]);
            tick();
            check("sweep_d_h", d_h, 32'h1 << i);
            check("sweep_code_h", code_h, i);
            check("sweep_valid_h", valid_h, 1'b1);
            check("sweep_d_l", d_l, ~(32'h1 << i) & 32'hFF);
        end

        // active-low decode of 011
        @(negedge clk);
        set_sel(3'b011);
        tick();
        check("al_d_l", d_l, 8'hF7);
        check("al_d_h", d_h, 8'h08);
        check("al_valid_l", valid_l, 1'b1);

        // enable gating
        @(negedge clk);
        set_sel(3'b110);
        tick();
        check("en_d_h", d_h, 8'h40);
        @(negedge clk);
        en = 1'b0;
        set_sel(3'b001);
        tick();
        check("dis_d_h", d_h, 8'h00);
        check("dis_valid_h", valid_h, 1'b0);
        check("dis_code_h", code_h, 3'b110);
        check("dis_d_l", d_l, 8'hFF);
        check("dis_valid_l", valid_l, 1'b0);
        @(negedge clk);
        en = 1'b1;
        tick();
        check("reen_d_h", d_h, 8'h02);
        check("reen_code_h", code_h, 3'b001);
        check("reen_valid_h", valid_h, 1'b1);

        // reset pulse between edges during a sweep
        @(negedge clk);
        set_sel(3'b100);
        tick();
        check("mid_pre_d_h", d_h, 8'h10);
        @(negedge clk);
        set_sel(3'b101);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_d_h", d_h, 8'h00);
        check("mid_rst_valid_h", valid_h, 1'b0);
        check("mid_rst_code_h", code_h, 3'b000);
        check("mid_rst_d_l", d_l, 8'hFF);
        rst = 1'b0;
        tick();
        check("resume_d_h", d_h, 8'h20);
        check("resume_code_h", code_h, 3'b101);
        check("resume_valid_h", valid_h, 1'b1);

        // mid-cycle select change must wait for the next edge
        @(negedge clk);
        set_sel(3'b010);
        tick();
        check("setup_a_d_h", d_h, 8'h04);
        #2 set_sel(3'b100);
        #1;
        check("setup_hold_d_h", d_h, 8'h04);
        check("setup_hold_ones", $countones(d_h), 1);
        tick();
        check("setup_b_d_h", d_h, 8'h10);
        check("setup_b_ones", $countones(d_h), 1);
        check("setup_b_code_h", code_h, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
